pipeline_hazard_ctrl: RTL and testbench

//  Sequences the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage RV64 core.

---
 rtl/pipeline_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV64 core: load-use bubbles, branch flushes,
// multi-cycle EX sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             id_is_mc,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned MC_CNT_W = 8;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_EXEC = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [MC_CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                lu;

    assign lu = ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    assign stall_count = stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Next state and zero-latency control outputs; branch abort outranks the MC sequence.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_busy      = (state_q == ST_MC_EXEC);

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mc_busy      = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_RUN;
            count_d      = '0;
        end else if (state_q == ST_MC_EXEC) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            if (count_q != '0) begin
                ex_mem_flush = 1'b1;
                count_d      = count_q - MC_CNT_W'(1);
            end else begin
                state_d = ST_RUN;
            end
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_valid && id_is_mc) begin
            state_d = ST_MC_EXEC;
            count_d = MC_CNT_W'(MC_LATENCY - 1);
        end
    end

    // Stall-cycle counter saturates instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, multi-cycle
// corner sequences and random stimulus against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MC_LATENCY = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int          STALL_MAX  = (1 << CNT_W) - 1;

    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush, mc_busy}
    localparam logic [6:0] O_NORMAL = 7'b1100000;
    localparam logic [6:0] O_LU     = 7'b0000100;
    localparam logic [6:0] O_BR     = 7'b1110110;
    localparam logic [6:0] O_RESET  = 7'b0010110;
    localparam logic [6:0] O_MC_RUN = 7'b0001011;
    localparam logic [6:0] O_MC_END = 7'b0001001;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic       is_mc;
        logic [4:0] ex_rd;
        logic       mem_read;
        logic       branch;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [6:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid, id_uses_rs2, id_is_mc, ex_mem_read, branch_taken;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush, mc_busy;
    logic [CNT_W-1:0] stall_count;
    logic [6:0]       outs;

    int n_tests = 0;
    int n_fail  = 0;
    int m_rem   = 0;
    int m_stall = 0;

    pipeline_hazard_ctrl #(.MC_LATENCY(MC_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_is_mc(id_is_mc), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mc_busy(mc_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush, mc_busy};

    function automatic in_t mk(logic v, int r1, int r2, logic u, logic mc, int rd, logic mr, logic br);
        in_t t;
        t.valid = v; t.rs1 = 5'(r1); t.rs2 = 5'(r2); t.uses = u; t.is_mc = mc;
        t.ex_rd = 5'(rd); t.mem_read = mr; t.branch = br;
        return t;
    endfunction

    function automatic bit model_lu(in_t v);
        return v.mem_read && v.ex_rd != 0 && v.valid &&
               (v.ex_rd == v.rs1 || (v.uses && v.ex_rd == v.rs2));
    endfunction

    // m_rem = MC cycles still to spend in EX (0 = not executing a multi-cycle op)
    function automatic logic [6:0] model_out(in_t v, int rem);
        if (v.branch)        return {6'b111011, rem > 0};
        else if (rem > 0)    return {5'b00010, rem > 1, 1'b1};
        else if (model_lu(v)) return O_LU;
        else                 return O_NORMAL;
    endfunction

    function automatic void model_adv(in_t v);
        logic [6:0] o;
        o = model_out(v, m_rem);
        if (!o[6] && m_stall < STALL_MAX) m_stall++;
        if (v.branch)                                m_rem = 0;
        else if (m_rem > 0)                          m_rem--;
        else if (!model_lu(v) && v.valid && v.is_mc) m_rem = MC_LATENCY;
    endfunction

    task automatic check7(string name, logic [6:0] act, logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check16(string name, logic [CNT_W-1:0] act, logic [CNT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: stall_count got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(in_t v);
        id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses;
        id_is_mc = v.is_mc; ex_rd = v.ex_rd; ex_mem_read = v.mem_read; branch_taken = v.branch;
    endtask

    // One cycle starting at a falling edge: drive, check, clock, advance model.
    task automatic step(in_t v, string name, bit use_exp, logic [6:0] exp_in);
        logic [6:0] e;
        apply(v);
        #2;
        e = use_exp ? exp_in : model_out(v, m_rem);
        check7(name, outs, e);
        check16({name, "_cnt"}, stall_count, CNT_W'(m_stall));
        @(posedge clk);
        model_adv(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_rem = 0;
        m_stall = 0;
    endtask

    vec_t tbl[10];
    in_t  idle, mc_in, br_in, lu_in, rv;
    int   s0;

    initial begin
        tbl[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), O_NORMAL};
        tbl[1] = '{mk(1, 5, 1, 0, 0, 5, 1, 0), O_LU};
        tbl[2] = '{mk(1, 1, 5, 1, 0, 5, 1, 0), O_LU};
        tbl[3] = '{mk(1, 0, 0, 1, 0, 0, 1, 0), O_NORMAL};
        tbl[4] = '{mk(1, 1, 5, 0, 0, 5, 1, 0), O_NORMAL};
        tbl[5] = '{mk(1, 5, 5, 1, 0, 5, 0, 0), O_NORMAL};
        tbl[6] = '{mk(0, 5, 5, 1, 0, 5, 1, 0), O_NORMAL};
        tbl[7] = '{mk(1, 7, 2, 1, 0, 7, 1, 1), O_BR};
        tbl[8] = '{mk(1, 1, 2, 1, 1, 0, 0, 1), O_BR};
        tbl[9] = '{mk(1, 3, 4, 1, 0, 9, 1, 0), O_NORMAL};

        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        mc_in = mk(1, 1, 2, 1, 1, 0, 0, 0);
        br_in = mk(0, 0, 0, 0, 0, 0, 0, 1);
        lu_in = mk(1, 6, 0, 0, 0, 6, 1, 0);

        reset = 1'b1;
        apply(idle);
        #3;
        check7("reset_out", outs, O_RESET);
        check16("reset_cnt", stall_count, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle patterns from RUN
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].in, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);
        end

        // Multi-cycle op: 4 busy cycles, result on the last, then PC resumes
        s0 = m_stall;
        step(mc_in, "mc_enter", 1'b1, O_NORMAL);
        for (int i = 0; i < 3; i++) step(idle, $sformatf("mc_run%0d", i), 1'b1, O_MC_RUN);
        step(idle, "mc_last", 1'b1, O_MC_END);
        step(idle, "mc_after", 1'b1, O_NORMAL);
        check16("mc_delta", stall_count, CNT_W'(s0 + 4));

        // Load-use during MC is masked
        step(mc_in, "mc2_enter", 1'b1, O_NORMAL);
        step(lu_in, "mc2_lu_masked", 1'b1, O_MC_RUN);
        for (int i = 0; i < 3; i++) step(idle, $sformatf("mc2_tail%0d", i), 1'b0, '0);

        // Branch in 2nd MC cycle aborts the op
        step(mc_in, "abort_enter", 1'b1, O_NORMAL);
        step(idle, "abort_mc1", 1'b1, O_MC_RUN);
        step(br_in, "abort_br", 1'b0, '0);
        check7("abort_br_flags", {outs[6:1], 1'b0}, {O_BR[6:1], 1'b0});
        step(idle, "abort_after", 1'b1, O_NORMAL);

        // Reset asserted mid-MC takes effect without a clock edge
        step(mc_in, "rst_enter", 1'b1, O_NORMAL);
        step(idle, "rst_mc1", 1'b1, O_MC_RUN);
        apply(idle);
        #2;
        reset = 1'b1;
        #1;
        check7("rst_async_out", outs, O_RESET);
        check16("rst_async_cnt", stall_count, '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_rem = 0;
        m_stall = 0;
        step(idle, "rst_release", 1'b1, O_NORMAL);

        // Random stimulus against the reference model
        for (int i = 0; i < 600; i++) begin
            rv = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            step(rv, $sformatf("rand%0d", i), 1'b0, '0);
        end

        // Saturation: 2^CNT_W + 3 stalled cycles
        reset = 1'b1;
        #2;
        do_reset();
        apply(lu_in);
        repeat ((1 << CNT_W) + 3) @(posedge clk);
        @(negedge clk);
        m_stall = STALL_MAX;
        check16("sat_value", stall_count, 16'hFFFF);
        step(lu_in, "sat_hold", 1'b1, O_LU);
        check16("sat_after", stall_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
